// File: rtl/conn90_bus_master.sv
// Board-side strobe/acknowledge master for the 90-pin backplane connector.
// Define CONN90_PARITY_EN to drive and check odd parity on pin 52.
module conn90_bus_master #(
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned TURN_CYC  = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_RW,
   input  logic [15:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic        BUSY,
   input  logic [90:1] JACK_IN,
   output logic [90:1] JACK_OUT,
   output logic [90:1] JACK_OE
);

   // state   | meaning
   // IDLE    | ready for a request, connector released
   // SETUP   | addr/rw (and write data) driven, STB low; waits out a stale ACK
   // STROBE  | STB high, waiting for ACK to rise
   // RELEASE | STB low, bus still driven, waiting for ACK to fall
   // TURN    | all drivers released; response issued on the final cycle
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_STROBE  = 3'd2,
      S_RELEASE = 3'd3,
      S_TURN    = 3'd4
   } state_t;

   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned SEQ_W = 4;
   localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(1);
   localparam logic [SEQ_W-1:0] SETUP_LOAD = SEQ_W'(SETUP_CYC - 1);
   localparam logic [SEQ_W-1:0] TURN_LOAD  = SEQ_W'(TURN_CYC - 1);
   localparam logic [SEQ_W-1:0] SEQ_ONE    = SEQ_W'(1);

   state_t           state_q, state_d;
   logic [SEQ_W-1:0] seq_q, seq_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             rw_q, rw_d;
   logic [15:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             rsp_err_q, rsp_err_d;
   logic             ack_meta_q, ack_meta_d;
   logic             ack_s_q, ack_s_d;
   logic             par_bad;
   logic             par_out;
   logic             unused_pins;

   assign unused_pins = ^{JACK_IN[90:52], JACK_IN[50:33]};

`ifdef CONN90_PARITY_EN
   assign par_bad = ~(^{JACK_IN[32:1], addr_q, JACK_IN[52]});
   assign par_out = ~(^{wdata_q, addr_q});
`else
   assign par_bad = 1'b0;
   assign par_out = 1'b0;
`endif

   assign ack_meta_d = JACK_IN[51];
   assign ack_s_d    = ack_meta_q;

   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      tmo_d       = tmo_q;
      rw_d        = rw_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               rw_d    = REQ_RW;
               addr_d  = REQ_ADDR;
               wdata_d = REQ_WDATA;
               rdata_d = '0;
               err_d   = 1'b0;
               seq_d   = SETUP_LOAD;
               tmo_d   = TMO_LOAD;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (seq_q != '0) begin
               seq_d = seq_q - SEQ_ONE;
            end else if (!ack_s_q) begin
               tmo_d   = TMO_LOAD;
               state_d = S_STROBE;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               seq_d   = TURN_LOAD;
               state_d = S_TURN;
            end else begin
               tmo_d = tmo_q - TMO_ONE;
            end
         end
         S_STROBE: begin
            if (ack_s_q) begin
               if (rw_q) begin
                  rdata_d = JACK_IN[32:1];
                  err_d   = par_bad;
               end
               tmo_d   = TMO_LOAD;
               state_d = S_RELEASE;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               seq_d   = TURN_LOAD;
               state_d = S_TURN;
            end else begin
               tmo_d = tmo_q - TMO_ONE;
            end
         end
         S_RELEASE: begin
            if (!ack_s_q) begin
               seq_d   = TURN_LOAD;
               state_d = S_TURN;
            end else if (tmo_q == '0) begin
               err_d   = 1'b1;
               seq_d   = TURN_LOAD;
               state_d = S_TURN;
            end else begin
               tmo_d = tmo_q - TMO_ONE;
            end
         end
         S_TURN: begin
            if (seq_q != '0) begin
               seq_d = seq_q - SEQ_ONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // response registers load on the edge entering the final TURN cycle
      if ((state_d == S_TURN) && (seq_d == '0)) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = rdata_d;
         rsp_err_d   = err_d;
      end
   end

   always_comb begin
      JACK_OUT = '0;
      JACK_OE  = '0;
      if ((state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_RELEASE)) begin
         JACK_OE[48:33]  = '1;
         JACK_OUT[48:33] = addr_q;
         JACK_OE[49]     = 1'b1;
         JACK_OUT[49]    = (state_q == S_STROBE);
         JACK_OE[50]     = 1'b1;
         JACK_OUT[50]    = rw_q;
         if (!rw_q) begin
            JACK_OE[32:1]  = '1;
            JACK_OUT[32:1] = wdata_q;
`ifdef CONN90_PARITY_EN
            JACK_OE[52]    = 1'b1;
            JACK_OUT[52]   = par_out;
`endif
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_IDLE;
         seq_q       <= '0;
         tmo_q       <= '0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         ack_meta_q  <= 1'b0;
         ack_s_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         seq_q       <= seq_d;
         tmo_q       <= tmo_d;
         rw_q        <= rw_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         ack_meta_q  <= ack_meta_d;
         ack_s_q     <= ack_s_d;
      end
   end

   assign REQ_READY = (state_q == S_IDLE);
   assign BUSY      = (state_q != S_IDLE);
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_conn90_bus_master.sv
// Scoreboard bench for conn90_bus_master with a cycle-stepped remote responder.
module tb_conn90_bus_master;

   localparam int SETUP_CYC = 2;
   localparam int TIMEOUT   = 8;
   localparam int TURN_CYC  = 1;
`ifdef CONN90_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ_VALID = 1'b0;
   logic        REQ_RW = 1'b0;
   logic [15:0] REQ_ADDR = '0;
   logic [31:0] REQ_WDATA = '0;
   logic        REQ_READY;
   logic        RSP_VALID;
   logic [31:0] RSP_RDATA;
   logic        RSP_ERR;
   logic        BUSY;
   logic [90:1] jack_in = '0;
   logic [90:1] JACK_OUT;
   logic [90:1] JACK_OE;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   rsp_cyc = 0;
   logic rsp_prev = 1'b0;

   conn90_bus_master #(
      .SETUP_CYC(SETUP_CYC),
      .TIMEOUT  (TIMEOUT),
      .TURN_CYC (TURN_CYC)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ_VALID(REQ_VALID),
      .REQ_READY(REQ_READY),
      .REQ_RW   (REQ_RW),
      .REQ_ADDR (REQ_ADDR),
      .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID),
      .RSP_RDATA(RSP_RDATA),
      .RSP_ERR  (RSP_ERR),
      .BUSY     (BUSY),
      .JACK_IN  (jack_in),
      .JACK_OUT (JACK_OUT),
      .JACK_OE  (JACK_OE)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void pins_exp(input logic rw, input logic [15:0] a, input logic [31:0] d,
                                    input logic stb, output logic [90:1] oe, output logic [90:1] out);
      oe  = '0;
      out = '0;
      oe[48:33]  = '1;
      out[48:33] = a;
      oe[49]     = 1'b1;
      out[49]    = stb;
      oe[50]     = 1'b1;
      out[50]    = rw;
      if (!rw) begin
         oe[32:1]  = '1;
         out[32:1] = d;
         if (PAR_EN) begin
            oe[52]  = 1'b1;
            out[52] = ~(^{d, a});
         end
      end
   endfunction

   task automatic push_exp(input logic [31:0] rd, input logic err);
      exp_q.push_back({rd, err});
   endtask

   always @(negedge CLK) begin
      if (RSP_VALID) begin
         chk("rsp_pulse", rsp_prev, 1'b0);
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", RSP_VALID, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_rdata", RSP_RDATA, mon_e.rdata);
            chk("rsp_err", RSP_ERR, mon_e.err);
            chk("turn_oe", JACK_OE, '0);
            rsp_cyc = cyc;
         end
      end
      rsp_prev = RSP_VALID;
   end

   // called on a falling edge; returns on the falling edge after the handshake
   task automatic do_req(input logic rw, input logic [15:0] a, input logic [31:0] d);
      logic [90:1] oe, out;
      int n;
      REQ_VALID = 1'b1;
      REQ_RW    = rw;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      n = 0;
      while (REQ_READY !== 1'b1 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("req_ready", REQ_READY, 1'b1);
      @(negedge CLK);
      hs_cyc    = cyc;
      REQ_VALID = 1'b0;
      pins_exp(rw, a, d, 1'b0, oe, out);
      chk("setup_busy", BUSY, 1'b1);
      chk("setup_oe", JACK_OE, oe);
      chk("setup_out", JACK_OUT, out);
   endtask

   task automatic remote(input bit respond, input int ack_dly, input int rel_dly,
                         input logic [31:0] rd, input logic par, input logic rw,
                         input logic [15:0] a, input logic [31:0] wd, output int stb_len);
      logic [90:1] oe, out;
      int n;
      n = 0;
      while (JACK_OUT[49] !== 1'b1 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("stb_rise", JACK_OUT[49], 1'b1);
      pins_exp(rw, a, wd, 1'b1, oe, out);
      chk("strobe_oe", JACK_OE, oe);
      chk("strobe_out", JACK_OUT, out);
      stb_len = 0;
      while (JACK_OUT[49] === 1'b1 && stb_len < 40) begin
         if (respond && stb_len == ack_dly) begin
            jack_in[51]   = 1'b1;
            jack_in[32:1] = rd;
            jack_in[52]   = par;
         end
         @(negedge CLK);
         stb_len++;
      end
      chk("stb_fall", JACK_OUT[49], 1'b0);
      if (respond) begin
         pins_exp(rw, a, wd, 1'b0, oe, out);
         chk("release_oe", JACK_OE, oe);
         chk("release_out", JACK_OUT, out);
         repeat (rel_dly) @(negedge CLK);
         jack_in[51]   = 1'b0;
         jack_in[32:1] = '0;
         jack_in[52]   = 1'b0;
      end
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      chk("rsp_pending", exp_q.size(), 0);
   endtask

   initial begin
      int len;
      int n;
      logic [31:0] d;

      repeat (3) @(negedge CLK);
      chk("rst_ready", REQ_READY, 1'b1);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_rsp_valid", RSP_VALID, 1'b0);
      chk("rst_rdata", RSP_RDATA, 32'h0);
      chk("rst_err", RSP_ERR, 1'b0);
      chk("rst_oe", JACK_OE, '0);
      chk("rst_out", JACK_OUT, '0);
      RST = 1'b0;
      @(negedge CLK);

      push_exp(32'h0, 1'b0);
      do_req(1'b0, 16'h1234, 32'hDEADBEEF);
      remote(1'b1, 3, 2, 32'h0, 1'b0, 1'b0, 16'h1234, 32'hDEADBEEF, len);
      wait_rsp();

      d = 32'hCAFEF00D;
      push_exp(d, 1'b0);
      do_req(1'b1, 16'h00FF, 32'h0);
      remote(1'b1, 2, 1, d, ~(^{d, 16'h00FF}), 1'b1, 16'h00FF, 32'h0, len);
      wait_rsp();

      // silent remote on a read: error response with cleared read data
      push_exp(32'h0, 1'b1);
      do_req(1'b1, 16'h0042, 32'h0);
      remote(1'b0, 0, 0, 32'h0, 1'b0, 1'b1, 16'h0042, 32'h0, len);
      chk("timeout_stb_len", len, TIMEOUT);
      chk("timeout_rsp_valid", RSP_VALID, 1'b1);
      chk("timeout_ready_turn", REQ_READY, 1'b0);
      @(negedge CLK);
      chk("timeout_ready_idle", REQ_READY, 1'b1);
      wait_rsp();

      jack_in[51] = 1'b1;
      repeat (3) @(negedge CLK);
      push_exp(32'h0, 1'b0);
      do_req(1'b0, 16'h0BAD, 32'h5555AAAA);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         chk("stale_stb", JACK_OUT[49], 1'b0);
         chk("stale_busy", BUSY, 1'b1);
      end
      jack_in[51] = 1'b0;
      remote(1'b1, 2, 1, 32'h0, 1'b0, 1'b0, 16'h0BAD, 32'h5555AAAA, len);
      wait_rsp();

      push_exp(32'h0, 1'b0);
      do_req(1'b0, 16'h0001, 32'h00000001);
      remote(1'b1, 1, 1, 32'h0, 1'b0, 1'b0, 16'h0001, 32'h00000001, len);
      wait_rsp();
      chk("min_write_latency", rsp_cyc - hs_cyc, 10);

      // wrong parity bit: flagged only when the parity check is built in
      push_exp(32'h00000001, PAR_EN);
      do_req(1'b1, 16'h0000, 32'h0);
      remote(1'b1, 2, 1, 32'h00000001, 1'b1, 1'b1, 16'h0000, 32'h0, len);
      wait_rsp();
      push_exp(32'h00000001, 1'b0);
      do_req(1'b1, 16'h0000, 32'h0);
      remote(1'b1, 2, 1, 32'h00000001, 1'b0, 1'b1, 16'h0000, 32'h0, len);
      wait_rsp();

      do_req(1'b0, 16'h7777, 32'h12345678);
      n = 0;
      while (JACK_OUT[49] !== 1'b1 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      chk("abort_stb_rise", JACK_OUT[49], 1'b1);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("abort_oe", JACK_OE, '0);
      chk("abort_busy", BUSY, 1'b0);
      chk("abort_ready", REQ_READY, 1'b1);
      chk("abort_rsp_valid", RSP_VALID, 1'b0);
      RST = 1'b0;
      repeat (20) @(negedge CLK);
      chk("abort_idle", BUSY, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/conn90_bus_master.md
Name: conn90_bus_master

Overview:
- Synchronous transaction engine that drives the board side of the 90-pin backplane connector, directly upstream of the connector pass-through.
- Accepts single read/write requests from local logic over a valid/ready handshake and runs a strobe/acknowledge cycle across the connector.
- Controls tristate turnaround, times out a silent remote, and returns read data or an error flag.

Parameters:
- SETUP_CYC, 2, cycles address/data are driven before STB rises (1..15).
- TIMEOUT, 255, max cycles waiting for ACK rise or fall before aborting (1..65535).
- TURN_CYC, 1, cycles with all drivers released before a new request is accepted (1..15).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY are both high.
- REQ_RW  in  1  1=read, 0=write.
- REQ_ADDR  in  16  target address.
- REQ_WDATA  in  32  write data.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_RDATA  out  32  read data, valid with RSP_VALID on reads.
- RSP_ERR  out  1  timeout or parity error, valid with RSP_VALID.
- BUSY  out  1  high in every state except IDLE.
- JACK_IN  in  [90:1]  connector pin sense.
- JACK_OUT  out  [90:1]  connector pin drive value.
- JACK_OE  out  [90:1]  per-pin drive enable; 1=drive.

Behaviour:
- Pin map:
  - [32:1] DATA.
  - [48:33] ADDR.
  - 49 STB, driven.
  - 50 RW, driven.
  - 51 ACK, input only.
  - 52 PAR.
  - 53..90: OUT=0 and OE=0 always.
- ACK synchroniser: JACK_IN[51] passes through a 2-flop synchroniser to give ack_s; the synchroniser is cleared by RST.
- Reset values: state IDLE, REQ_READY=1, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=0, BUSY=0, JACK_OUT=0, JACK_OE=0.
- Reset mid-transaction: all OE drop on the same edge. No RSP_VALID is issued for the aborted transaction.
- IDLE:
  - REQ_READY=1.
  - On handshake, latch RW, ADDR and WDATA; load the counter; go to SETUP.
- SETUP:
  - OE=1 on ADDR, RW and STB; STB=0.
  - DATA OE=1 only on writes.
  - After SETUP_CYC cycles, go to STROBE if ack_s=0.
  - If ack_s=1 (stale ACK), stay in SETUP until ack_s=0. If TIMEOUT expires first, set err and go to TURN.
- STROBE:
  - STB=1; the timeout counter starts at 0.
  - On ack_s=1: for a read, capture JACK_IN[32:1] into the read-data register on that edge; go to RELEASE.
  - If the counter reaches TIMEOUT with ack_s=0: set err, go to TURN, and drop STB on the same edge.
- RELEASE:
  - STB=0; ADDR, RW and DATA stay driven.
  - Counter restarts. On ack_s=0 go to TURN; if TIMEOUT elapses first, set err and go to TURN.
- TURN:
  - All OE=0 for TURN_CYC cycles, then go to IDLE.
  - RSP_VALID=1 for exactly one cycle, on the cycle TURN exits.
  - RSP_RDATA and RSP_ERR update with RSP_VALID and hold until the next response. On writes, RSP_RDATA=0.
- REQ_VALID is ignored outside IDLE. A request held across TURN is accepted on the first IDLE cycle.
- Minimum write latency (SETUP_CYC=2, TURN_CYC=1, remote ACK after 1 cycle, 2-flop sync): handshake edge to RSP_VALID is 10 cycles.
- Timeout counter is sized to cover TIMEOUT and saturates; it never wraps.

Optional Feature:
- CONN90_PARITY_EN defined:
  - PAR pin (52) is driven whenever DATA is driven, as odd parity over DATA[32:1] and ADDR[48:33].
  - On reads, JACK_IN[52] is sampled with the data; odd parity over captured data plus the latched ADDR is checked.
  - A parity mismatch sets RSP_ERR=1; data is still returned.
- CONN90_PARITY_EN undefined:
  - Pin 52 OUT=0, OE=0, no check.
  - RSP_ERR reports timeouts only.

Test Plan:
- Write ADDR=0x1234, WDATA=0xDEADBEEF, remote ACK 3 cycles after STB and release 2 cycles after STB falls -> pins [48:33]=0x1234 and [32:1]=0xDEADBEEF with OE=1 during SETUP/STROBE/RELEASE; single RSP_VALID, RSP_ERR=0; all OE=0 in TURN.
- Read ADDR=0x00FF, remote drives 0xCAFEF00D and ACK -> DATA OE=0 throughout; RSP_RDATA=0xCAFEF00D, RSP_ERR=0.
- No ACK with TIMEOUT=8 -> STB high for 8 cycles then drops; RSP_VALID with RSP_ERR=1, RSP_RDATA=0; REQ_READY=1 TURN_CYC cycles later.
- ACK stuck high before request -> FSM holds in SETUP with STB=0; ACK released after 4 cycles -> normal completion with RSP_ERR=0.
- RST asserted on the 2nd STROBE cycle -> next edge: JACK_OE=0, BUSY=0, REQ_READY=1, no RSP_VALID.
- CONN90_PARITY_EN: read returning 0x00000001 at ADDR=0x0000 with PAR=1 -> RSP_ERR=1 (correct odd parity is 0). Same read with PAR=0 -> RSP_ERR=0.
